ad1_spi_responder: RTL and testbench

- Emulates the two-channel PMOD AD1 serial ADC as an SPI responder. It answers the existing ADC SPI initiator's chip select and serial clock with two MISO streams.
- Enables on-chip loopback and hardware-in-the-loop testing of the PI control path without the physical converter.
- Parallel 12-bit samples are loaded from fabric, for example from the DAC-side control value or a test pattern generator.

---
 rtl/ad1_spi_responder.sv | 160 ++++++++++++++++
 tb/tb_ad1_spi_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ad1_spi_responder.sv
// PMOD AD1 emulator: answers an SPI initiator's CS/SCLK with two MISO streams
// built from parallel samples loaded by the fabric.
module ad1_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int LEAD_ZEROS  = 4,
    parameter int DATA_BITS   = 12
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 adc_cs_out,
    input  logic                 adc_sclk,
    output logic                 adc_miso0,
    output logic                 adc_miso1,
    input  logic [DATA_BITS-1:0] sample0_in,
    input  logic [DATA_BITS-1:0] sample1_in,
    input  logic                 sample_load,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic                 sample_overrun
);

    localparam int F  = LEAD_ZEROS + DATA_BITS;
    localparam int CW = $clog2(F + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync;
    logic cs_q, sclk_q;
    logic cs_s, sclk_s;
    logic cs_fall, cs_rise, sclk_fall;

    logic [DATA_BITS-1:0] hold0, hold1;
    logic hold_fresh;

    logic [F-1:0] shift0, shift1, shift0_n, shift1_n;
    logic [CW-1:0] count, count_n;
    logic take, done_n, abort_n;

    // Synchronizers idle high so reset release never looks like an edge
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cs_sync   <= '1;
            sclk_sync <= '1;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], adc_cs_out};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], adc_sclk};
            cs_q      <= cs_s;
            sclk_q    <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_q & ~cs_s;
    assign cs_rise   = ~cs_q & cs_s;
    assign sclk_fall = sclk_q & ~sclk_s;

    always_comb begin
        state_n  = state;
        shift0_n = shift0;
        shift1_n = shift1;
        count_n  = count;
        take     = 1'b0;
        done_n   = 1'b0;
        abort_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    shift0_n = {{LEAD_ZEROS{1'b0}}, hold0};
                    shift1_n = {{LEAD_ZEROS{1'b0}}, hold1};
                    count_n  = '0;
                    take     = 1'b1;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                // CS rising beats a coincident SCLK fall
                if (cs_rise) begin
                    abort_n = 1'b1;
                    state_n = IDLE;
                end else if (sclk_fall) begin
                    shift0_n = {shift0[F-2:0], 1'b0};
                    shift1_n = {shift1[F-2:0], 1'b0};
                    count_n  = count + 1'b1;
                    if (count == CW'(F - 1)) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state  <= IDLE;
            shift0 <= '0;
            shift1 <= '0;
            count  <= '0;
        end else begin
            state  <= state_n;
            shift0 <= shift0_n;
            shift1 <= shift1_n;
            count  <= count_n;
        end
    end

    // A frame consumes the held sample; a coincident load refills it
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            hold0          <= '0;
            hold1          <= '0;
            hold_fresh     <= 1'b0;
            sample_overrun <= 1'b0;
        end else begin
            sample_overrun <= sample_load & hold_fresh & ~take;
            if (sample_load) begin
                hold0      <= sample0_in;
                hold1      <= sample1_in;
                hold_fresh <= 1'b1;
            end else if (take) begin
                hold0      <= '0;
                hold1      <= '0;
                hold_fresh <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            adc_miso0   <= 1'b0;
            adc_miso1   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            adc_miso0   <= (state == SHIFT) & shift0[F-1];
            adc_miso1   <= (state == SHIFT) & shift1[F-1];
            busy        <= (state_n == SHIFT);
            frame_done  <= done_n;
            frame_abort <= abort_n;
        end
    end

endmodule

// File: tb/tb_ad1_spi_responder.sv
// Bench for ad1_spi_responder: directed and random frames checked against
// a sample-level model of the emulated converter.
module tb_ad1_spi_responder;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    logic cs = 1'b1;
    logic sclk = 1'b1;
    logic load = 1'b0;
    logic [11:0] s0 = '0;
    logic [11:0] s1 = '0;
    logic miso0, miso1, busy, done, abort, ovr;

    ad1_spi_responder dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .adc_cs_out    (cs),
        .adc_sclk      (sclk),
        .adc_miso0     (miso0),
        .adc_miso1     (miso1),
        .sample0_in    (s0),
        .sample1_in    (s1),
        .sample_load   (load),
        .busy          (busy),
        .frame_done    (done),
        .frame_abort   (abort),
        .sample_overrun(ovr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_abort = 0;
    int n_ovr = 0;
    int busy_err = 0;
    logic busy_prev = 1'b0;

    // Pulse counters; busy must fall exactly when frame_done rises
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (busy || !busy_prev) busy_err++;
        end
        if (abort) n_abort++;
        if (ovr) n_ovr++;
        busy_prev = busy;
    end

    logic [11:0] m_h0 = '0;
    logic [11:0] m_h1 = '0;
    bit m_fresh = 0;
    int e_ovr = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [11:0] a, input logic [11:0] b);
        @(posedge clk) #1;
        s0 = a;
        s1 = b;
        load = 1'b1;
        @(posedge clk) #1;
        load = 1'b0;
        if (m_fresh) e_ovr++;
        m_h0 = a;
        m_h1 = b;
        m_fresh = 1;
    endtask

    task automatic pulse();
        sclk = 1'b0;
        repeat (5) @(posedge clk);
        #1 sclk = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    // One CS-low window of npulse SCLK pulses; bits are read just before
    // each falling edge, i.e. while the initiator would be sampling.
    task automatic frame(input int npulse, input bit coll,
                         input logic [11:0] c0, input logic [11:0] c1,
                         input string tag);
        logic [15:0] b0, b1, e0, e1;
        logic extra, mb;
        int d0, a0, n, sh;
        b0 = '0;
        b1 = '0;
        extra = 1'b0;
        mb = 1'b0;
        d0 = n_done;
        a0 = n_abort;
        e0 = 16'(m_h0);
        e1 = 16'(m_h1);
        if (coll) begin
            m_h0 = c0;
            m_h1 = c1;
            m_fresh = 1;
        end else begin
            m_h0 = '0;
            m_h1 = '0;
            m_fresh = 0;
        end
        @(posedge clk) #1 cs = 1'b0;
        if (coll) begin
            @(posedge clk);
            @(posedge clk) #1;
            s0 = c0;
            s1 = c1;
            load = 1'b1;
            @(posedge clk) #1 load = 1'b0;
            repeat (5) @(posedge clk);
        end else begin
            repeat (8) @(posedge clk);
        end
        for (int i = 0; i < npulse; i++) begin
            @(posedge clk) #1;
            if (i < 16) begin
                b0[15-i] = miso0;
                b1[15-i] = miso1;
            end else begin
                extra = extra | miso0 | miso1;
            end
            if (i == 1) mb = busy;
            pulse();
        end
        repeat (6) @(posedge clk);
        #1 cs = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n = (npulse < 16) ? npulse : 16;
        sh = 16 - n;
        chk({tag, ".miso0"}, 32'(b0 >> sh), 32'(e0 >> sh));
        chk({tag, ".miso1"}, 32'(b1 >> sh), 32'(e1 >> sh));
        if (npulse > 1) chk({tag, ".busy_mid"}, 32'(mb), 32'(1));
        chk({tag, ".done_cnt"}, 32'(n_done - d0), 32'(npulse >= 16));
        chk({tag, ".abort_cnt"}, 32'(n_abort - a0), 32'(npulse < 16));
        chk({tag, ".idle_out"}, 32'({miso0, miso1, busy}), 32'(0));
        chk({tag, ".overrun_cnt"}, 32'(n_ovr), 32'(e_ovr));
        if (npulse > 16) chk({tag, ".extra_zero"}, 32'(extra), 32'(0));
    endtask

    initial begin
        logic [11:0] r0, r1;
        int np;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({miso0, miso1, busy, done, abort, ovr}), 32'(0));
        reset_b = 1'b1;

        // Reset asserted in the middle of a frame
        do_load(12'hFFF, 12'hFFF);
        @(posedge clk) #1 cs = 1'b0;
        repeat (8) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk) #1;
            pulse();
        end
        @(posedge clk) #1;
        chk("pre_reset_miso0", 32'(miso0), 32'(1));
        chk("pre_reset_busy", 32'(busy), 32'(1));
        #3 reset_b = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({miso0, miso1, busy, done, abort, ovr}), 32'(0));
        cs = 1'b1;
        sclk = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_b = 1'b1;
        m_h0 = '0;
        m_h1 = '0;
        m_fresh = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_idle", 32'({miso0, miso1, busy}), 32'(0));

        do_load(12'hA5C, 12'h3FF);
        frame(16, 0, '0, '0, "nominal");

        do_load(12'h5A5, 12'h0F3);
        frame(7, 0, '0, '0, "abort");
        frame(16, 0, '0, '0, "after_abort");

        do_load(12'h111, 12'h111);
        do_load(12'h222, 12'h222);
        frame(16, 0, '0, '0, "overrun");

        do_load(12'h123, 12'h123);
        frame(16, 1, 12'h0F0, 12'h0F0, "coll_cur");
        frame(16, 0, '0, '0, "coll_next");

        do_load(12'h9C3, 12'h6E1);
        frame(20, 0, '0, '0, "extra");

        for (int k = 0; k < 8; k++) begin
            r0 = 12'($urandom);
            r1 = 12'($urandom);
            do_load(r0, r1);
            if ($urandom_range(0, 1) == 1) do_load(12'($urandom), 12'($urandom));
            np = $urandom_range(5, 20);
            frame(np, 0, '0, '0, "random");
        end

        chk("done_busy_align", 32'(busy_err), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
